// File: rtl/mcu_spi_slave_regif.sv
// SPI mode-0 responder that turns {rw, addr, data} frames into single-cycle register strobes on clk.
// Pins are oversampled, so edges act SYNC_STAGES+1 clk late. Read data must arrive before the next SCK fall or RD_LATE_VALUE is sent.
module mcu_spi_slave_regif #(
   parameter int                ADDR_W        = 7,
   parameter int                DATA_W        = 16,
   parameter int                SYNC_STAGES   = 2,
   parameter logic [DATA_W-1:0] RD_LATE_VALUE = 16'hDEAD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck_i,
   input  logic              spi_cs_n_i,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   output logic              spi_miso_t,
   output logic              reg_wr_en,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_rd_addr,
   input  logic [DATA_W-1:0] reg_rd_data,
   input  logic              reg_rd_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int HDR_LEN   = 1 + ADDR_W;
   localparam int FRAME_LEN = HDR_LEN + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(HDR_LEN);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WR_DATA,
      S_RD_WAIT,
      S_RD_DATA,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, cs_n_sync, mosi_sync;
   logic                   sck_d, cs_n_d;
   logic                   sck_s, cs_n_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_fall, cs_rise;

   logic [CNT_W-1:0]   bit_cnt, cnt_plus;
   // The receive register doubles as header and data shifter, so it must be wide enough for the address.
   logic [DATA_W-2:0]  rx_sr;
   logic [HDR_LEN-1:0] hdr_now;
   logic [DATA_W-1:0]  data_now;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  tx_sr, tx_src;

   logic cnt_en, cnt_clr, hdr_done, rd_fire, wr_fire, err_fire, tx_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_n_sync <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_n_d    <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sck_d     <= sck_s;
         cs_n_d    <= cs_n_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_n_s   = cs_n_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_fall  = ~cs_n_s & cs_n_d;
   assign cs_rise  = cs_n_s & ~cs_n_d;

   assign cnt_plus = bit_cnt + CNT_W'(1);
   assign hdr_now  = {rx_sr[ADDR_W-1:0], mosi_s};
   assign data_now = {rx_sr, mosi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      hdr_done  = 1'b0;
      rd_fire   = 1'b0;
      wr_fire   = 1'b0;
      err_fire  = 1'b0;
      tx_shift  = 1'b0;
      tx_src    = tx_sr;
      case (state)
         S_IDLE: begin
            if (cs_fall) begin
               state_nxt = S_HDR;
               cnt_clr   = 1'b1;
            end
         end
         S_HDR: begin
            if (sck_rise) begin
               cnt_en = 1'b1;
               if (cnt_plus == HDR_CNT) begin
                  hdr_done = 1'b1;
                  if (hdr_now[ADDR_W]) begin
                     rd_fire   = 1'b1;
                     state_nxt = S_RD_WAIT;
                  end else begin
                     state_nxt = S_WR_DATA;
                  end
               end
            end
         end
         S_WR_DATA: begin
            if (sck_rise) begin
               cnt_en = 1'b1;
               if (cnt_plus == FRAME_CNT) begin
                  wr_fire   = 1'b1;
                  state_nxt = S_DONE;
               end
            end
         end
         S_RD_WAIT: begin
            if (sck_rise) cnt_en = 1'b1;
            // Valid data coinciding with the deadline edge still counts as on time.
            if (sck_fall) begin
               tx_src    = reg_rd_valid ? reg_rd_data : RD_LATE_VALUE;
               tx_shift  = 1'b1;
               err_fire  = ~reg_rd_valid;
               state_nxt = S_RD_DATA;
            end else if (reg_rd_valid) begin
               tx_src    = reg_rd_data;
               state_nxt = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (sck_fall) tx_shift = 1'b1;
            if (sck_rise) begin
               cnt_en = 1'b1;
               if (cnt_plus == FRAME_CNT) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      // Deselect overrides whatever the frame was doing; a partial frame is reported, never committed.
      if (cs_rise && state != S_IDLE) begin
         state_nxt = S_IDLE;
         cnt_en    = 1'b0;
         hdr_done  = 1'b0;
         rd_fire   = 1'b0;
         wr_fire   = 1'b0;
         tx_shift  = 1'b0;
         tx_src    = tx_sr;
         err_fire  = (bit_cnt != '0) && (bit_cnt != FRAME_CNT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         rx_sr       <= '0;
         addr_q      <= '0;
         tx_sr       <= '0;
         spi_miso_o  <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         reg_rd_en   <= 1'b0;
         reg_rd_addr <= '0;
         frame_err   <= 1'b0;
      end else begin
         reg_wr_en <= wr_fire;
         reg_rd_en <= rd_fire;
         frame_err <= err_fire;
         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (cnt_en) begin
            bit_cnt <= cnt_plus;
            rx_sr   <= data_now[DATA_W-2:0];
         end
         if (hdr_done) addr_q <= hdr_now[ADDR_W-1:0];
         if (rd_fire) reg_rd_addr <= hdr_now[ADDR_W-1:0];
         if (wr_fire) begin
            reg_wr_addr <= addr_q;
            reg_wr_data <= data_now;
         end
         if (tx_shift) begin
            spi_miso_o <= tx_src[DATA_W-1];
            tx_sr      <= {tx_src[DATA_W-2:0], 1'b0};
         end else begin
            tx_sr <= tx_src;
            if (state_nxt != S_RD_DATA) spi_miso_o <= 1'b0;
         end
      end
   end

   assign busy       = (state != S_IDLE);
   assign spi_miso_t = (state == S_IDLE);

endmodule
